// File: rtl/ex_fwd_pkg.sv
// ex_fwd_pkg: forward select codes and shadow pipeline slot types for ex_forward_ctrl.
package ex_fwd_pkg;
    localparam int RA_W = 5;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
    } ex_slot_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            reg_write;
    } mw_slot_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forward select for one EX operand; the MEM result beats WB, x0 never forwards.
module fwd_sel
    import ex_fwd_pkg::*;
(
    input  logic [RA_W-1:0] rs,
    input  logic            use_rs,
    input  mw_slot_t        mem,
    input  mw_slot_t        wb,
    output logic [1:0]      sel
);
    logic mem_hit, wb_hit;
    assign mem_hit = mem.reg_write && (mem.rd != '0) && (mem.rd == rs);
    assign wb_hit  = wb.reg_write && (wb.rd != '0) && (wb.rd == rs);
    assign sel = !use_rs ? FWD_REG : mem_hit ? FWD_EXMEM : wb_hit ? FWD_WB : FWD_REG;
endmodule

// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX operand forwarding and load-use stall control with a stall-cycle counter.
module ex_forward_ctrl
    import ex_fwd_pkg::*;
#(
    parameter int REG_AW = RA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    if (REG_AW != RA_W) begin : g_aw_check
        $error("REG_AW must equal ex_fwd_pkg::RA_W");
    end

    ex_slot_t ex_q;
    mw_slot_t mem_q, wb_q;

    // The load leaves EX after one edge, so the stall never lasts more than a cycle.
    assign stall_o = !flush_i && ex_q.mem_read && (ex_q.rd != '0) &&
                     ((id_use_rs1_i && id_rs1_i == ex_q.rd) || (id_use_rs2_i && id_rs2_i == ex_q.rd));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_o <= '0;
        end else begin
            ex_q <= (stall_o || flush_i) ? '0 :
                    '{rs1: id_rs1_i, rs2: id_rs2_i, use_rs1: id_use_rs1_i, use_rs2: id_use_rs2_i,
                      rd: id_rd_i, reg_write: id_reg_write_i, mem_read: id_mem_read_i};
            mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
            wb_q  <= mem_q;
            if (stall_o) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    fwd_sel u_fwd_a (.rs(ex_q.rs1), .use_rs(ex_q.use_rs1), .mem(mem_q), .wb(wb_q), .sel(fwd_a_o));
    fwd_sel u_fwd_b (.rs(ex_q.rs2), .use_rs(ex_q.use_rs2), .mem(mem_q), .wb(wb_q), .sel(fwd_b_o));
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: directed forwarding, load-use stall, flush and async reset checks.
module tb_ex_forward_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
    logic        id_reg_write_i = 1'b0, id_mem_read_i = 1'b0, flush_i = 1'b0;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        stall_o;
    logic [15:0] stall_cnt_o;
    int checks = 0;
    int failures = 0;

    ex_forward_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .flush_i(flush_i),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic rw, input logic mr);
        id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_use_rs1_i = u1; id_use_rs2_i = u2;
        id_reg_write_i = rw; id_mem_read_i = mr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic nops(input int n);
        id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        #3;
        chk("rst_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        #9 rst_i = 1'b1;
        nops(3);

        // add x5,x1,x2 ; sub x7,x5,x1
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd7, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b_stall", 32'(stall_o), 32'd0);
        tick();
        chk("b2b_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("b2b_fwd_b", 32'(fwd_b_o), 32'd0);
        nops(3);

        // add x5 ; nop ; or x8,x2,x5
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        nops(1);
        id(5'd8, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("wb_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("wb_fwd_b", 32'(fwd_b_o), 32'd1);
        nops(3);

        // add x5 ; add x5 ; sub x9,x5,x5
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd9, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("prio_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("prio_fwd_b", 32'(fwd_b_o), 32'd2);
        nops(3);

        // lw x6,0(x1) ; add x4,x3,x6
        id(5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        id(5'd4, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_cnt0", 32'(stall_cnt_o), 32'd0);
        tick();
        chk("lu_stall_1cyc", 32'(stall_o), 32'd0);
        chk("lu_cnt1", 32'(stall_cnt_o), 32'd1);
        chk("lu_bubble_b", 32'(fwd_b_o), 32'd0);
        tick();
        chk("lu_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("lu_fwd_b", 32'(fwd_b_o), 32'd1);
        chk("lu_cnt_hold", 32'(stall_cnt_o), 32'd1);
        nops(3);

        // add x0 ; sub x7,x0,x0 ; lw x0 ; use x0
        id(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("x0_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("x0_fwd_b", 32'(fwd_b_o), 32'd0);
        id(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        id(5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("x0_lw_stall", 32'(stall_o), 32'd0);
        nops(3);
        chk("x0_cnt", 32'(stall_cnt_o), 32'd1);

        // lw x6 in EX, dependent in ID, flush
        id(5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        id(5'd4, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("fl_stall", 32'(stall_o), 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_bubble_stall", 32'(stall_o), 32'd0);
        chk("fl_cnt", 32'(stall_cnt_o), 32'd1);
        tick();
        chk("fl_bubble_fwd_b", 32'(fwd_b_o), 32'd1);
        nops(3);

        // add x1 ; lw x6,0(x1) ; dependent -> reset mid-stall
        id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rs_pre_fwd_a", 32'(fwd_a_o), 32'd2);
        id(5'd4, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rs_pre_stall", 32'(stall_o), 32'd1);
        chk("rs_pre_cnt", 32'(stall_cnt_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rs_fwd_a", 32'(fwd_a_o), 32'd0);
        chk("rs_fwd_b", 32'(fwd_b_o), 32'd0);
        chk("rs_stall", 32'(stall_o), 32'd0);
        chk("rs_cnt", 32'(stall_cnt_o), 32'd0);
        #1 rst_i = 1'b1;
        id(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        id(5'd7, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("rel_fwd_a", 32'(fwd_a_o), 32'd2);
        chk("rel_cnt", 32'(stall_cnt_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
